// File: rtl/circuit1_checker.sv
// circuit1_checker: self-test sequencer for out = ~((A & B) | C).
// Steps {A,B,C} through 0..7, samples dut_out after SETTLE_CYCLES
// cycles per vector and compares against the golden table EXPECTED.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           begin a run (accepted only in IDLE)
//   dut_out         output of the circuit under test
//   A, B, C         vector applied to the circuit (A = MSB)
//   busy            high while vectors are applied
//   done            one-cycle pulse at end of run
//   pass            last completed run had no mismatches
//   err_count       mismatching vectors in current/last run
//   fail_map        bit i set if vector i mismatched
//   first_fail_idx  first mismatching vector (valid with fail_valid)
//   fail_valid      at least one mismatch recorded this run
module circuit1_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_map,
    output logic [2:0] first_fail_idx,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       mismatch;
    logic [3:0] err_next;

    // idx is held after the run, so the last vector stays applied
    assign {A, B, C} = idx;

    assign mismatch = (dut_out != EXPECTED[idx]);
    assign err_next = err_count + {3'b000, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 3'd0;
            cnt            <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            fail_map       <= 8'h00;
            first_fail_idx <= 3'd0;
            fail_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= APPLY;
                        busy           <= 1'b1;
                        idx            <= 3'd0;
                        cnt            <= 4'd0;
                        pass           <= 1'b0;
                        err_count      <= 4'd0;
                        fail_map       <= 8'h00;
                        first_fail_idx <= 3'd0;
                        fail_valid     <= 1'b0;
                    end
                end
                APPLY: begin
                    if (cnt == LAST) begin
                        cnt <= 4'd0;
                        if (mismatch) begin
                            err_count     <= err_next;
                            fail_map[idx] <= 1'b1;
                            if (!fail_valid) begin
                                first_fail_idx <= idx;
                                fail_valid     <= 1'b1;
                            end
                        end
                        if (idx == 3'd7) begin
                            // pass reflects the final count, incl. vector 7
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 4'd0);
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
